// File: rtl/cmp_ctrl_pkg.sv
// Shared types and constants for the serial magnitude-compare controller.
// The early-exit variant is selected with the CMP_EARLY_EXIT_EN macro.
package cmp_ctrl_pkg;

    // Width of the one shared compare slice.
    localparam int CMP_CHUNK = 3;

    typedef enum logic [1:0] {
        CMP_IDLE,
        CMP_COMPARE,
        CMP_DONE
    } cmp_state_t;

    // Sticky compare outcome. It stays EQ until the first differing chunk.
    typedef enum logic [1:0] {
        CMP_RES_EQ,
        CMP_RES_LT,
        CMP_RES_GT
    } cmp_res_t;

endpackage

// File: rtl/mag_cmp_slice.sv
// Combinational 3-bit unsigned magnitude compare.
// Per-bit less/greater/equal terms are resolved by an MSB-first priority cascade.
import cmp_ctrl_pkg::*;

module mag_cmp_slice (
    input  logic [CMP_CHUNK-1:0] a,
    input  logic [CMP_CHUNK-1:0] b,
    output logic                 lt,
    output logic                 gt,
    output logic                 eq
);

    logic [CMP_CHUNK-1:0] bl, bg, be;

    // Per-bit terms.
    for (genvar i = 0; i < CMP_CHUNK; i++) begin : g_bit
        assign bl[i] = ~a[i] &  b[i];
        assign bg[i] =  a[i] & ~b[i];
        assign be[i] = ~(a[i] ^ b[i]);
    end

    // MSB-priority cascade: a lower bit only decides if every higher bit matched.
    always_comb begin
        logic eq_run;
        lt     = 1'b0;
        gt     = 1'b0;
        eq_run = 1'b1;
        for (int i = CMP_CHUNK - 1; i >= 0; i--) begin
            lt     = lt | (eq_run & bl[i]);
            gt     = gt | (eq_run & bg[i]);
            eq_run = eq_run & be[i];
        end
        eq = eq_run;
    end

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial unsigned magnitude comparator. It steps one 3-bit slice over the
// operand chunks, MSB chunk first, and uses a start/busy/done handshake.
// Optional build macro CMP_EARLY_EXIT_EN: finish on the first differing chunk.
// Without it, every compare takes a fixed NCHUNK+1 cycles.
import cmp_ctrl_pkg::*;

module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 12,
    parameter int CHUNK = CMP_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lesser,
    output logic             greater,
    output logic             equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Parameter sanity checks at elaboration time.
    if ((WIDTH % CHUNK) != 0) begin : g_width_chk
        $error("serial_mag_cmp_ctrl: WIDTH must be a multiple of CHUNK");
    end
    if (CHUNK != CMP_CHUNK) begin : g_chunk_chk
        $error("serial_mag_cmp_ctrl: CHUNK is fixed by the slice width");
    end

    cmp_state_t       state, state_nxt;
    cmp_res_t         res, res_nxt;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic             s_lt, s_gt, s_eq;

    // Only the latched operand copies reach the slice.
    mag_cmp_slice u_slice (
        .a  (a_q[idx*CHUNK +: CHUNK]),
        .b  (b_q[idx*CHUNK +: CHUNK]),
        .lt (s_lt),
        .gt (s_gt),
        .eq (s_eq)
    );

    assign busy = (state != CMP_IDLE);
    assign done = (state == CMP_DONE);

    // Sticky result update: only the first differing chunk is recorded.
    always_comb begin
        res_nxt = res;
        if (state == CMP_COMPARE && res == CMP_RES_EQ && !s_eq)
            res_nxt = s_lt ? CMP_RES_LT : CMP_RES_GT;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= CMP_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            CMP_IDLE:    if (start) state_nxt = CMP_COMPARE;
            CMP_COMPARE: begin
                if (idx == '0)
                    state_nxt = CMP_DONE;
`ifdef CMP_EARLY_EXIT_EN
                else if (res == CMP_RES_EQ && !s_eq)
                    state_nxt = CMP_DONE;
`endif
            end
            CMP_DONE:    state_nxt = CMP_IDLE;
            default:     state_nxt = CMP_IDLE;
        endcase
    end

    // Operand capture, chunk down-counter, sticky flag and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            res     <= CMP_RES_EQ;
            lesser  <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                CMP_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx     <= IDXW'(NCHUNK - 1);
                        res     <= CMP_RES_EQ;
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                        equal   <= 1'b0;
                    end
                end
                CMP_COMPARE: begin
                    res <= res_nxt;
                    if (idx != '0) idx <= idx - 1'b1;
                    // Results are published as DONE is entered, so they are valid with done.
                    if (state_nxt == CMP_DONE) begin
                        lesser  <= (res_nxt == CMP_RES_LT);
                        greater <= (res_nxt == CMP_RES_GT);
                        equal   <= (res_nxt == CMP_RES_EQ);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Self-checking bench for serial_mag_cmp_ctrl (WIDTH=12). It uses directed
// cases plus randomized back-to-back compares checked against an arithmetic model.
module tb_serial_mag_cmp_ctrl;

    localparam int WIDTH  = 12;
    localparam int CHUNK  = 3;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, lesser, greater, equal;

    int nchk  = 0;
    int nfail = 0;

    // Expected results of the previous compare, used for the hold check.
    logic have_prev = 1'b0;
    logic [2:0] prev_exp;

    serial_mag_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .lesser  (lesser),
        .greater (greater),
        .equal   (equal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result as {lesser, greater, equal}.
    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {x < y, x > y, x == y};
    endfunction

    // Reference done cycle, counted from the cycle in which start is sampled.
    function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef CMP_EARLY_EXIT_EN
        int base;
        for (int j = 0; j < NCHUNK; j++) begin
            base = 1 << (CHUNK * (NCHUNK - 1 - j));
            if ((int'(x) / base) % 8 != (int'(y) / base) % 8) return j + 2;
        end
`endif
        return NCHUNK + 1;
    endfunction

    // Drive start with operands for one cycle. On return, the bench is sampling cycle 1.
    // If a result is pending, first check that it is still held in the idle cycle.
    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        if (have_prev) begin
            chk("hold_res", {lesser, greater, equal}, prev_exp);
            chk("hold_idle", {busy, done}, 2'b00);
        end
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        chk("busy_c1", {busy, done}, 2'b10);
    endtask

    // Wait for done (bounded), then check latency and results. Returns at the done cycle.
    task automatic wait_check(input string tag, input logic [2:0] exp, input int lat);
        int cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, {lesser, greater, equal}, exp);
        chk({tag, "_busy"}, busy, 1'b1);
        have_prev = 1'b1;
        prev_exp  = exp;
    endtask

    task automatic do_cmp(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        start_op(x, y);
        wait_check(tag, ref_res(x, y), ref_lat(x, y));
    endtask

    initial begin
        logic [WIDTH-1:0] x, y;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", {busy, done, lesser, greater, equal}, 5'b0);
        rst = 1'b0;

        // Directed cases.
        do_cmp("t1_eq",     12'o5123, 12'o5123);
        do_cmp("t2_msb_gt", 12'o4000, 12'o3777);
        do_cmp("t3_lsb_lt", 12'o1234, 12'o1235);
        do_cmp("t4_sticky", 12'o7000, 12'o0777);

        // Start while busy is ignored. The restart at cycle 6 is accepted.
        start_op(12'o1234, 12'o1235);               // sampling cycle 1
        @(negedge clk);                             // cycle 2
        start = 1'b1; a = 12'o7777; b = 12'o0000;
        @(negedge clk);                             // cycle 3
        start = 1'b0;
        @(negedge clk);                             // cycle 4
        chk("t5_nodone_c4", done, 1'b0);
        @(negedge clk);                             // cycle 5
        chk("t5_done_c5", done, 1'b1);
        chk("t5_res_c5", {lesser, greater, equal}, 3'b100);
        start = 1'b1; a = 12'o0000; b = 12'o7777;
        @(negedge clk);                             // cycle 6
        chk("t5_hold_c6", {busy, lesser, greater, equal}, 4'b0100);
        a = 12'o5123; b = 12'o5123;
        @(negedge clk);                             // cycle 7
        start = 1'b0;
        chk("t5_cleared_c7", {busy, lesser, greater, equal}, 4'b1000);
        begin
            int cyc = 7;
            while (!done && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            chk("t5_lat", cyc, 11);
            chk("t5_res", {lesser, greater, equal}, 3'b001);
        end
        have_prev = 1'b1; prev_exp = 3'b001;

        // Reset mid-operation aborts without a done pulse.
        start_op(12'o0000, 12'o7777);               // sampling cycle 1
        @(negedge clk);                             // cycle 2
        rst = 1'b1;
        @(negedge clk);                             // cycle 3
        rst = 1'b0;
        chk("t6_rst_out", {busy, done, lesser, greater, equal}, 5'b0);
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                seen += done;
            end
            chk("t6_no_done", seen, 0);
        end
        have_prev = 1'b0;
        do_cmp("t6_after", 12'o0070, 12'o0007);

        // Randomized back-to-back compares. Some pairs are equal or differ in one chunk.
        for (int n = 0; n < 60; n++) begin
            x = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ WIDTH'(32'($urandom_range(1, 7)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
                default: y = WIDTH'($urandom);
            endcase
            do_cmp("rnd", x, y);
        end

        @(negedge clk);
        chk("final_hold", {lesser, greater, equal}, prev_exp);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
